// File: rtl/usb_tx_fifo_sched.sv
// IN-packet scheduler: moves one packet at a time from an endpoint TX FIFO to the SIE byte path.
// Optional packet/abort statistics counters are built when USB_TX_SCHED_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for an SIE IN request; fill count sampled here
// LOAD  | one-cycle read strobe to the active endpoint FIFO
// WAIT  | FIFO read latency; capture byte into txData
// SEND  | byte presented to SIE, waiting for txDataReady
// DONE  | packet complete pulse
// ABORT | packet aborted by flush of the active FIFO
module usb_tx_fifo_sched #(
  parameter int NUM_EP   = 4,
  parameter int EP_SEL_W = 2,
  parameter int CNT_W    = 16,
  parameter int MAX_PKT  = 64,
  parameter int LEN_W    = 7
) (
  input  logic                      usbClk,
  input  logic                      rstN,
  input  logic                      inReq,
  input  logic [EP_SEL_W-1:0]       inEp,
  output logic                      inReqAck,
  input  logic [NUM_EP*CNT_W-1:0]   numElementsInFifo,
  input  logic [NUM_EP-1:0]         forceEmptySyncToUsbClk,
  input  logic [NUM_EP*8-1:0]       fifoData,
  output logic [NUM_EP-1:0]         fifoREn,
  output logic [7:0]                txData,
  output logic                      txDataValid,
  input  logic                      txDataReady,
  output logic                      pktDone,
  output logic                      pktAborted,
  output logic [LEN_W-1:0]          pktLen,
  output logic                      busy,
  output logic [15:0]               pktCount,
  output logic [7:0]                abortCount
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, SEND, DONE, ABORT} stateT;

  localparam logic [CNT_W-1:0]    MAX_PKT_C = CNT_W'(MAX_PKT);
  localparam logic [LEN_W-1:0]    MAX_PKT_L = LEN_W'(MAX_PKT);
  localparam logic [EP_SEL_W:0]   NUM_EP_C  = (EP_SEL_W+1)'(NUM_EP);

  stateT               state, stateNext;
  logic [EP_SEL_W-1:0] ep, epNext;
  logic [LEN_W-1:0]    remaining, remainingNext;
  logic [LEN_W-1:0]    sent, sentNext;
  logic [7:0]          txDataNext;
  logic                txDataValidNext;

  logic [CNT_W-1:0]    fillArr [NUM_EP];
  logic [7:0]          dataArr [NUM_EP];
  logic [CNT_W-1:0]    reqFill;
  logic [LEN_W-1:0]    reqLen;
  logic                epValid;
  logic                flushHit;

  always_comb begin
    for (int k = 0; k < NUM_EP; k++) begin
      fillArr[k] = numElementsInFifo[k*CNT_W +: CNT_W];
      dataArr[k] = fifoData[k*8 +: 8];
    end
  end

  // Length is clamped at full count width before truncation so large fills cannot alias.
  assign reqFill  = fillArr[inEp];
  assign reqLen   = (reqFill > MAX_PKT_C) ? MAX_PKT_L : reqFill[LEN_W-1:0];
  assign epValid  = ({1'b0, inEp} < NUM_EP_C);
  assign flushHit = forceEmptySyncToUsbClk[ep];

  assign fifoREn = (state == LOAD) ? (NUM_EP'(1) << ep) : '0;
  assign busy    = (state != IDLE);

  always_ff @(posedge usbClk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      ep          <= '0;
      remaining   <= '0;
      sent        <= '0;
      txData      <= '0;
      txDataValid <= 1'b0;
    end else begin
      state       <= stateNext;
      ep          <= epNext;
      remaining   <= remainingNext;
      sent        <= sentNext;
      txData      <= txDataNext;
      txDataValid <= txDataValidNext;
    end
  end

  always_comb begin
    stateNext       = state;
    epNext          = ep;
    remainingNext   = remaining;
    sentNext        = sent;
    txDataNext      = txData;
    txDataValidNext = txDataValid;
    inReqAck        = 1'b0;
    pktDone         = 1'b0;
    pktAborted      = 1'b0;
    pktLen          = '0;
    case (state)
      IDLE: begin
        if (inReq) begin
          inReqAck = 1'b1;
          if (epValid) begin
            epNext        = inEp;
            remainingNext = reqLen;
            sentNext      = '0;
            stateNext     = (reqLen == '0) ? DONE : LOAD;
          end else begin
            pktAborted = 1'b1;
          end
        end
      end
      LOAD: stateNext = flushHit ? ABORT : WAIT;
      WAIT: begin
        if (flushHit) begin
          stateNext = ABORT;
        end else begin
          txDataNext      = dataArr[ep];
          txDataValidNext = 1'b1;
          stateNext       = SEND;
        end
      end
      SEND: begin
        // A flush in the handshake cycle wins: the byte is dropped and not counted.
        if (flushHit) begin
          txDataValidNext = 1'b0;
          stateNext       = ABORT;
        end else if (txDataReady) begin
          txDataValidNext = 1'b0;
          sentNext        = sent + LEN_W'(1);
          remainingNext   = remaining - LEN_W'(1);
          stateNext       = (remaining == LEN_W'(1)) ? DONE : LOAD;
        end
      end
      DONE: begin
        pktDone   = 1'b1;
        pktLen    = sent;
        stateNext = IDLE;
      end
      ABORT: begin
        pktAborted = 1'b1;
        pktLen     = sent;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef USB_TX_SCHED_STATS_EN
  always_ff @(posedge usbClk or negedge rstN) begin
    if (!rstN) begin
      pktCount   <= '0;
      abortCount <= '0;
    end else begin
      if (pktDone && (pktCount != '1))
        pktCount <= pktCount + 16'd1;
      if (pktAborted && (abortCount != '1))
        abortCount <= abortCount + 8'd1;
    end
  end
`else
  assign pktCount   = '0;
  assign abortCount = '0;
`endif

endmodule

// File: tb/tb_usb_tx_fifo_sched.sv
// Bench for usb_tx_fifo_sched: queue-based FIFO/SIE model, directed plus randomized packets.
module tb_usb_tx_fifo_sched;
  localparam int NUM_EP  = 4;
  localparam int CNT_W   = 16;
  localparam int MAX_PKT = 64;
  localparam int LEN_W   = 7;

  logic                    usbClk = 1'b0;
  logic                    rstN;
  logic                    inReq;
  logic [1:0]              inEp;
  logic                    inReqAck;
  logic [NUM_EP*CNT_W-1:0] numElementsInFifo;
  logic [NUM_EP-1:0]       forceEmptySyncToUsbClk;
  logic [NUM_EP*8-1:0]     fifoData;
  logic [NUM_EP-1:0]       fifoREn;
  logic [7:0]              txData;
  logic                    txDataValid;
  logic                    txDataReady;
  logic                    pktDone;
  logic                    pktAborted;
  logic [LEN_W-1:0]        pktLen;
  logic                    busy;
  logic [15:0]             pktCount;
  logic [7:0]              abortCount;

  usb_tx_fifo_sched dut (
    .usbClk(usbClk), .rstN(rstN), .inReq(inReq), .inEp(inEp), .inReqAck(inReqAck),
    .numElementsInFifo(numElementsInFifo), .forceEmptySyncToUsbClk(forceEmptySyncToUsbClk),
    .fifoData(fifoData), .fifoREn(fifoREn), .txData(txData), .txDataValid(txDataValid),
    .txDataReady(txDataReady), .pktDone(pktDone), .pktAborted(pktAborted), .pktLen(pktLen),
    .busy(busy), .pktCount(pktCount), .abortCount(abortCount)
  );

  always #5 usbClk = ~usbClk;

  int errCnt = 0;
  int chkCnt = 0;
  int expPkt = 0;
  int expAbt = 0;
  logic [7:0] q [NUM_EP][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic updFill();
    for (int k = 0; k < NUM_EP; k++)
      numElementsInFifo[k*CNT_W +: CNT_W] = CNT_W'(q[k].size());
  endtask

  task automatic loadFifo(input int ep, input int n);
    repeat (n) q[ep].push_back(8'($urandom));
    updFill();
  endtask

  task automatic flushQ(input int ep);
    q[ep].delete();
    updFill();
  endtask

  // One cycle: FIFO model pops on the strobe so the byte is ready during the following cycle.
  task automatic tick();
    @(negedge usbClk);
    for (int k = 0; k < NUM_EP; k++) begin
      if (fifoREn[k]) begin
        if (q[k].size() > 0) fifoData[k*8 +: 8] = q[k].pop_front();
        else fifoData[k*8 +: 8] = 8'h00;
      end
    end
    updFill();
  endtask

  task automatic checkStats(input string tag);
`ifdef USB_TX_SCHED_STATS_EN
    chk({tag, "_pktCount"}, pktCount, expPkt);
    chk({tag, "_abortCount"}, abortCount, expAbt);
`else
    chk({tag, "_pktCount"}, pktCount, 0);
    chk({tag, "_abortCount"}, abortCount, 0);
`endif
  endtask

  task automatic runPkt(input int ep, input int stallByte, input int stallLen,
                        input int flushByte, input int flushEp, input bit rndReady,
                        input string tag);
    logic [7:0] expB[$];
    logic [7:0] got[$];
    logic [7:0] held;
    logic [3:0] epMask;
    int expLen, expCnt, reads, cyc, stallLeft, b, lenObs;
    bit done, aborted, isAbort, stableOk, onehotOk, noAckOk, prevStall, flushDone, rdy;
    expLen = (q[ep].size() > MAX_PKT) ? MAX_PKT : q[ep].size();
    for (int i = 0; i < expLen; i++) expB.push_back(q[ep][i]);
    isAbort = (flushEp == ep) && (flushByte >= 0) && (flushByte < expLen);
    expCnt  = isAbort ? flushByte : expLen;
    epMask  = 4'(1 << ep);
    reads = 0; cyc = 0; lenObs = 0; stallLeft = stallLen; held = 8'h00;
    done = 0; aborted = 0; stableOk = 1; onehotOk = 1; noAckOk = 1; prevStall = 0; flushDone = 0;

    inReq = 1'b1;
    inEp  = 2'(ep);
    #1;
    chk({tag, "_ack"}, inReqAck, 1);
    while (!done && !aborted && cyc < 2000) begin
      tick();
      cyc++;
      reads += $countones(fifoREn);
      if (fifoREn != 4'b0 && fifoREn != epMask) onehotOk = 0;
      if (inReqAck) noAckOk = 0;
      if (prevStall && (txData !== held || !txDataValid)) stableOk = 0;
      if (pktDone || pktAborted) begin
        done = pktDone;
        aborted = pktAborted;
        lenObs = int'(pktLen);
      end
      txDataReady = 1'b0;
      forceEmptySyncToUsbClk = '0;
      prevStall = 0;
      if (done || aborted) begin
        inReq = 1'b0;
      end else begin
        inReq = 1'($urandom_range(0, 1));
        inEp  = 2'($urandom_range(0, 3));
      end
      if (!done && !aborted && txDataValid) begin
        b = got.size();
        if (b == stallByte && stallLeft > 0) begin
          stallLeft--;
          rdy = 0;
        end else if (rndReady && $urandom_range(0, 2) == 0) begin
          rdy = 0;
        end else begin
          rdy = 1;
        end
        if (b == flushByte && rdy && !flushDone) begin
          forceEmptySyncToUsbClk[flushEp] = 1'b1;
          flushQ(flushEp);
          flushDone = 1;
        end
        txDataReady = rdy;
        if (rdy && !forceEmptySyncToUsbClk[ep]) got.push_back(txData);
        if (!rdy) begin
          prevStall = 1;
          held = txData;
        end
      end
    end
    inReq = 1'b0;
    txDataReady = 1'b0;
    forceEmptySyncToUsbClk = '0;

    chk({tag, "_finished"}, done | aborted, 1);
    chk({tag, "_done"}, done, !isAbort);
    chk({tag, "_aborted"}, aborted, isAbort);
    chk({tag, "_pktLen"}, lenObs, expCnt);
    chk({tag, "_nbytes"}, got.size(), expCnt);
    for (int i = 0; i < expCnt && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), got[i], expB[i]);
    chk({tag, "_reads"}, reads, isAbort ? flushByte + 1 : expLen);
    chk({tag, "_onehot"}, onehotOk, 1);
    chk({tag, "_noBusyAck"}, noAckOk, 1);
    chk({tag, "_stable"}, stableOk, 1);
    if (!rndReady && !isAbort)
      chk({tag, "_cycles"}, cyc,
          (expLen == 0) ? 1 : 3*expLen + 1 + ((stallByte >= 0 && stallByte < expLen) ? stallLen : 0));
    if (isAbort) expAbt++;
    else expPkt++;
    tick();
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_noRen"}, fifoREn, 0);
    checkStats(tag);
  endtask

  initial begin
    int ep;
    rstN = 1'b0;
    inReq = 1'b0;
    inEp = '0;
    txDataReady = 1'b0;
    forceEmptySyncToUsbClk = '0;
    fifoData = '0;
    numElementsInFifo = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", txDataValid, 0);
    chk("rst_ren", fifoREn, 0);
    chk("rst_ack", inReqAck, 0);
    checkStats("rst");
    rstN = 1'b1;
    tick();

    loadFifo(1, 5);
    runPkt(1, -1, 0, -1, -1, 0, "t1");

    loadFifo(0, 200);
    runPkt(0, -1, 0, -1, -1, 0, "t2a");
    chk("t2a_left", q[0].size(), 136);
    runPkt(0, -1, 0, -1, -1, 0, "t2b");
    chk("t2b_left", q[0].size(), 72);

    runPkt(2, -1, 0, -1, -1, 0, "t3");

    loadFifo(3, 10);
    runPkt(3, 3, 7, -1, -1, 0, "t4");

    loadFifo(1, 8);
    runPkt(1, -1, 0, 2, 1, 0, "t5a");
    loadFifo(1, 8);
    runPkt(1, -1, 0, 3, 0, 0, "t5b");

    for (int n = 0; n < 20; n++) begin
      ep = $urandom_range(0, 3);
      loadFifo(ep, $urandom_range(0, 90));
      runPkt(ep, $urandom_range(0, 10), $urandom_range(0, 4),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1,
             $urandom_range(0, 3), 1, $sformatf("rnd%0d", n));
    end

    loadFifo(2, 20);
    inReq = 1'b1;
    inEp = 2'd2;
    tick();
    inReq = 1'b0;
    for (int i = 0; i < 50 && !txDataValid; i++) tick();
    chk("t6_inSend", txDataValid, 1);
    #1 rstN = 1'b0;
    #1;
    chk("t6_valid", txDataValid, 0);
    chk("t6_txData", txData, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ren", fifoREn, 0);
    chk("t6_pktLen", pktLen, 0);
    chk("t6_flags", {pktDone, pktAborted, inReqAck}, 0);
    expPkt = 0;
    expAbt = 0;
    checkStats("t6_rst");
    tick();
    rstN = 1'b1;
    for (int k = 0; k < NUM_EP; k++) flushQ(k);

    loadFifo(0, 3);
    runPkt(0, -1, 0, -1, -1, 0, "t6_p1");
    loadFifo(1, 2);
    runPkt(1, -1, 0, -1, -1, 0, "t6_p2");
    runPkt(2, -1, 0, -1, -1, 0, "t6_p3");
    loadFifo(3, 4);
    runPkt(3, -1, 0, 1, 3, 0, "t6_ab");
`ifdef USB_TX_SCHED_STATS_EN
    chk("t6_final_pkt", pktCount, 3);
    chk("t6_final_abt", abortCount, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
